// File: rtl/fpu_pkg.sv
// Shared definitions for the FP register-file/issue controller: op codes,
// op-class decode and the control part of the completion tag.
package fpu_pkg;

  localparam int unsigned FPU_OP_WIDTH = 5;

  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FNEG       = 5'd0;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FABS       = 5'd1;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FADD       = 5'd2;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FSUB       = 5'd3;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FMUL       = 5'd4;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FINV       = 5'd5;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FINV_INIT  = 5'd6;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FSQRT_INIT = 5'd7;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_ITOF       = 5'd8;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FTOI       = 5'd9;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FMV        = 5'd10;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FOR        = 5'd11;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FORI       = 5'd12;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_SET        = 5'd13;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_GET        = 5'd14;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FCLT       = 5'd15;
  localparam logic [FPU_OP_WIDTH-1:0] FPU_OP_FCZ        = 5'd16;

  // Routing bits carried in the upper end of the completion tag.
  typedef struct packed {
    logic ret;
    logic wcc;
    logic wreg;
  } fpu_tag_ctl_t;

  localparam int unsigned FPU_TAG_CTL_W = $bits(fpu_tag_ctl_t);

  typedef struct packed {
    logic wreg;    // result written to reg[y]
    logic wcc;     // compare result written to cond[cc]
    logic ret;     // data result returned to the core
    logic imm1;    // operand a is the immediate
    logic imm2;    // operand b is the immediate
    logic zero_b;  // operand b is forced to zero
  } fpu_op_class_t;

  function automatic fpu_op_class_t fpu_decode(input logic [FPU_OP_WIDTH-1:0] op);
    fpu_op_class_t c;
    c = '0;
    case (op)
      FPU_OP_FNEG, FPU_OP_FABS, FPU_OP_FADD, FPU_OP_FSUB, FPU_OP_FMUL,
      FPU_OP_FINV, FPU_OP_FINV_INIT, FPU_OP_FSQRT_INIT, FPU_OP_FMV: c.wreg = 1'b1;
      FPU_OP_ITOF: begin c.wreg = 1'b1; c.imm1 = 1'b1; end
      FPU_OP_FORI: begin c.wreg = 1'b1; c.imm2 = 1'b1; end
      FPU_OP_SET:  begin c.wreg = 1'b1; c.imm1 = 1'b1; c.zero_b = 1'b1; end
      FPU_OP_GET:  begin c.ret = 1'b1; c.zero_b = 1'b1; end
      FPU_OP_FTOI: c.ret = 1'b1;
      FPU_OP_FCLT, FPU_OP_FCZ: c.wcc = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // Immediate/move ops all execute as a bitwise OR in the arithmetic unit.
  function automatic logic [FPU_OP_WIDTH-1:0] fpu_ex_op(input logic [FPU_OP_WIDTH-1:0] op);
    if (op == FPU_OP_FORI || op == FPU_OP_SET || op == FPU_OP_GET) return FPU_OP_FOR;
    return op;
  endfunction

endpackage

// File: rtl/fpu_regfile_ctl_scoreboard.sv
// Scoreboard: per-register and per-flag busy bits, in-flight counter,
// hazard stall, issue handshake and sticky protocol error.
module fpu_scoreboard
  import fpu_pkg::*;
#(
  parameter int unsigned REG_COUNT    = 32,
  parameter int unsigned COND_COUNT   = 8,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned CC_W         = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid_i,
  input  logic            ex_ready_i,
  input  logic            use_x1_i,
  input  logic [REG_W-1:0] x1_i,
  input  logic            use_x2_i,
  input  logic [REG_W-1:0] x2_i,
  input  logic            wreg_i,
  input  logic            wcc_i,
  input  logic [REG_W-1:0] y_i,
  input  logic [CC_W-1:0]  cc_i,
  input  logic            cmp_valid_i,
  input  logic            cmp_wreg_i,
  input  logic            cmp_wcc_i,
  input  logic [REG_W-1:0] cmp_y_i,
  input  logic [CC_W-1:0]  cmp_cc_i,
  output logic            ex_valid_o,
  output logic            req_ready_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [REG_COUNT-1:0]  reg_busy_q, reg_busy_d, reg_clr, reg_set, reg_live;
  logic [COND_COUNT-1:0] cc_busy_q, cc_busy_d, cc_clr, cc_set, cc_live;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic                  err_q, err_d;
  logic                  stall, accept, dec;

  // Completion clears and accept sets; bits cleared this cycle no longer block issue.
  always_comb begin
    reg_clr = '0;
    cc_clr  = '0;
    reg_set = '0;
    cc_set  = '0;
    if (cmp_valid_i && cmp_wreg_i) reg_clr[cmp_y_i]  = 1'b1;
    if (cmp_valid_i && cmp_wcc_i)  cc_clr[cmp_cc_i]  = 1'b1;
    reg_live = reg_busy_q & ~reg_clr;
    cc_live  = cc_busy_q & ~cc_clr;
    stall = (use_x1_i && reg_live[x1_i]) ||
            (use_x2_i && reg_live[x2_i]) ||
            (wreg_i && reg_live[y_i]) ||
            (wcc_i && cc_live[cc_i]) ||
            (inflight_q == CNT_W'(MAX_INFLIGHT) && !cmp_valid_i);
    ex_valid_o  = rstn && req_valid_i && !stall;
    req_ready_o = rstn && ex_ready_i && !stall;
    accept      = ex_valid_o && req_ready_o;
    if (accept && wreg_i) reg_set[y_i] = 1'b1;
    if (accept && wcc_i)  cc_set[cc_i] = 1'b1;
    // Set after clear so a bit retired and reclaimed in one cycle stays busy.
    reg_busy_d = (reg_busy_q & ~reg_clr) | reg_set;
    cc_busy_d  = (cc_busy_q & ~cc_clr) | cc_set;
    dec = cmp_valid_i && (inflight_q != '0);
    inflight_d = inflight_q;
    if (accept && !dec)      inflight_d = inflight_q + 1'b1;
    else if (!accept && dec) inflight_d = inflight_q - 1'b1;
    err_d = err_q;
    if (cmp_valid_i && ((inflight_q == '0) ||
                        (cmp_wreg_i && !reg_busy_q[cmp_y_i]) ||
                        (cmp_wcc_i && !cc_busy_q[cmp_cc_i])))
      err_d = 1'b1;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reg_busy_q <= '0;
      cc_busy_q  <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      reg_busy_q <= reg_busy_d;
      cc_busy_q  <= cc_busy_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign busy_o = (inflight_q != '0);
  assign err_o  = err_q;

endmodule

// File: rtl/fpu_regfile_ctl.sv
// FP register file and issue controller: decodes requests, resolves operands
// with completion forwarding, issues to the execution unit and retires results.
module fpu_regfile_ctl
  import fpu_pkg::*;
#(
  parameter int unsigned REG_COUNT    = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned COND_COUNT   = 8,
  parameter int unsigned MAX_INFLIGHT = 4,
  localparam int unsigned REG_W = $clog2(REG_COUNT),
  localparam int unsigned CC_W  = (COND_COUNT > 1) ? $clog2(COND_COUNT) : 1,
  localparam int unsigned TAG_W = FPU_TAG_CTL_W + CC_W + REG_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [FPU_OP_WIDTH-1:0] req_op,
  input  logic [REG_W-1:0]        req_x1,
  input  logic [REG_W-1:0]        req_x2,
  input  logic [REG_W-1:0]        req_y,
  input  logic [CC_W-1:0]         req_cc,
  input  logic [DATA_W-1:0]       req_imm,
  output logic                    ex_valid,
  input  logic                    ex_ready,
  output logic [FPU_OP_WIDTH-1:0] ex_op,
  output logic [DATA_W-1:0]       ex_a,
  output logic [DATA_W-1:0]       ex_b,
  output logic [TAG_W-1:0]        ex_tag,
  input  logic                    cmp_valid,
  input  logic [TAG_W-1:0]        cmp_tag,
  input  logic [DATA_W-1:0]       cmp_y32,
  input  logic                    cmp_y1,
  output logic [COND_COUNT-1:0]   cond,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    busy,
  output logic                    err
);

  logic [DATA_W-1:0]     rf_q [REG_COUNT];
  logic [COND_COUNT-1:0] cond_q, cond_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;

  fpu_op_class_t cls;
  fpu_tag_ctl_t  req_ctl, cmp_ctl;
  logic [CC_W-1:0]  cmp_cc;
  logic [REG_W-1:0] cmp_y;
  logic             fwd1, fwd2;

  assign cmp_ctl = fpu_tag_ctl_t'(cmp_tag[TAG_W-1 -: FPU_TAG_CTL_W]);
  assign cmp_cc  = cmp_tag[REG_W +: CC_W];
  assign cmp_y   = cmp_tag[REG_W-1:0];

  // Request decode, operand resolution with forwarding, and issue tag.
  always_comb begin
    cls = fpu_decode(req_op);
    req_ctl.ret  = cls.ret;
    req_ctl.wcc  = cls.wcc;
    req_ctl.wreg = cls.wreg;
    fwd1 = cmp_valid && cmp_ctl.wreg && (cmp_y == req_x1);
    fwd2 = cmp_valid && cmp_ctl.wreg && (cmp_y == req_x2);
    if (cls.imm1)  ex_a = req_imm;
    else if (fwd1) ex_a = cmp_y32;
    else           ex_a = rf_q[req_x1];
    if (cls.zero_b)    ex_b = '0;
    else if (cls.imm2) ex_b = req_imm;
    else if (fwd2)     ex_b = cmp_y32;
    else               ex_b = rf_q[req_x2];
    ex_op  = fpu_ex_op(req_op);
    ex_tag = {req_ctl, req_cc, req_y};
  end

  fpu_scoreboard #(
    .REG_COUNT   (REG_COUNT),
    .COND_COUNT  (COND_COUNT),
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .REG_W       (REG_W),
    .CC_W        (CC_W)
  ) u_sb (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid_i(req_valid),
    .ex_ready_i (ex_ready),
    .use_x1_i   (!cls.imm1),
    .x1_i       (req_x1),
    .use_x2_i   (!cls.imm2 && !cls.zero_b),
    .x2_i       (req_x2),
    .wreg_i     (cls.wreg),
    .wcc_i      (cls.wcc),
    .y_i        (req_y),
    .cc_i       (req_cc),
    .cmp_valid_i(cmp_valid),
    .cmp_wreg_i (cmp_ctl.wreg),
    .cmp_wcc_i  (cmp_ctl.wcc),
    .cmp_y_i    (cmp_y),
    .cmp_cc_i   (cmp_cc),
    .ex_valid_o (ex_valid),
    .req_ready_o(req_ready),
    .busy_o     (busy),
    .err_o      (err)
  );

  // Register file write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (cmp_valid && cmp_ctl.wreg) rf_q[cmp_y] <= cmp_y32;
  end

  // Next-state for condition flags and the core return port.
  always_comb begin
    cond_d      = cond_q;
    out_valid_d = cmp_valid && cmp_ctl.ret;
    out_data_d  = out_data_q;
    if (cmp_valid && cmp_ctl.wcc) cond_d[cmp_cc] = cmp_y1;
    if (cmp_valid && cmp_ctl.ret) out_data_d = cmp_y32;
  end

  // Condition flags and return-data registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cond_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cond_q      <= cond_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign cond      = cond_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fpu_regfile_ctl.sv
// Directed self-checking bench for fpu_regfile_ctl with default parameters.
module tb_fpu_regfile_ctl;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready;
  logic [4:0]  req_op, req_x1, req_x2, req_y;
  logic [2:0]  req_cc;
  logic [31:0] req_imm;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_op;
  logic [31:0] ex_a, ex_b;
  logic [10:0] ex_tag;
  logic        cmp_valid;
  logic [10:0] cmp_tag;
  logic [31:0] cmp_y32;
  logic        cmp_y1;
  logic [7:0]  cond;
  logic        out_valid;
  logic [31:0] out_data;
  logic        busy, err;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] F1 = 32'h3F80_0000;  // 1.0
  localparam logic [31:0] F2 = 32'h4000_0000;  // 2.0
  localparam logic [31:0] F3 = 32'h4040_0000;  // 3.0
  localparam logic [31:0] F9 = 32'h4110_0000;  // 9.0

  fpu_regfile_ctl #(.REG_COUNT(32), .DATA_W(32), .COND_COUNT(8), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x1(req_x1), .req_x2(req_x2), .req_y(req_y), .req_cc(req_cc), .req_imm(req_imm),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
    .ex_tag(ex_tag), .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_y32(cmp_y32),
    .cmp_y1(cmp_y1), .cond(cond), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Tag layout {ret, wcc, wreg, cc[2:0], y[4:0]}.
  function automatic logic [10:0] mk_tag(input logic r, input logic c, input logic w,
                                         input logic [2:0] cc, input logic [4:0] y);
    return {r, c, w, cc, y};
  endfunction

  task automatic present(input logic [4:0] op, input logic [4:0] x1, input logic [4:0] x2,
                         input logic [4:0] y, input logic [2:0] cc, input logic [31:0] imm);
    req_valid = 1'b1; req_op = op; req_x1 = x1; req_x2 = x2; req_y = y; req_cc = cc; req_imm = imm;
  endtask

  task automatic complete(input logic [10:0] tag, input logic [31:0] y32, input logic y1);
    cmp_valid = 1'b1; cmp_tag = tag; cmp_y32 = y32; cmp_y1 = y1;
  endtask

  task automatic idle();
    req_valid = 1'b0; cmp_valid = 1'b0;
  endtask

  // Issue SET reg<-val and complete it the following cycle.
  task automatic do_set(input logic [4:0] y, input logic [31:0] val);
    present(FPU_OP_SET, 5'd0, 5'd0, y, 3'd0, val);
    @(posedge clk); #1;
    req_valid = 1'b0;
    complete(mk_tag(1'b0, 1'b0, 1'b1, 3'd0, y), val, 1'b0);
    @(posedge clk); #1;
    cmp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; ex_ready = 1'b1; cmp_valid = 1'b0; cmp_tag = '0; cmp_y32 = '0; cmp_y1 = 1'b0;
    present(FPU_OP_SET, 5'd0, 5'd0, 5'd1, 3'd0, F1);
    #2;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid: got %b expected 0", ex_valid); end
    checks++; if (cond !== 8'h00) begin errors++; $display("FAIL rst_cond: got %h expected 00", cond); end
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL rst_out: got %b/%h expected 0/0", out_valid, out_data); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_busy_err: got %b/%b expected 0/0", busy, err); end
    idle();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_set_get();
    present(FPU_OP_SET, 5'd0, 5'd0, 5'd3, 3'd0, F1);
    #1;
    checks++; if (ex_valid !== 1'b1 || req_ready !== 1'b1) begin errors++; $display("FAIL set_issue: got ev=%b rr=%b expected 1/1", ex_valid, req_ready); end
    checks++; if (ex_op !== FPU_OP_FOR) begin errors++; $display("FAIL set_ex_op: got %0d expected %0d", ex_op, FPU_OP_FOR); end
    checks++; if (ex_a !== F1 || ex_b !== 32'h0) begin errors++; $display("FAIL set_operands: got %h/%h expected %h/0", ex_a, ex_b, F1); end
    checks++; if (ex_tag !== 11'h103) begin errors++; $display("FAIL set_tag: got %h expected 103", ex_tag); end
    @(posedge clk); #1;
    idle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL set_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    complete(11'h103, F1, 1'b0);
    @(posedge clk); #1;
    cmp_valid = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL set_done: got busy=%b ov=%b expected 0/0", busy, out_valid); end
    present(FPU_OP_GET, 5'd3, 5'd0, 5'd0, 3'd0, 32'h0);
    #1;
    checks++; if (ex_a !== F1 || ex_tag !== 11'h400) begin errors++; $display("FAIL get_issue: got a=%h tag=%h expected %h/400", ex_a, ex_tag, F1); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    complete(11'h400, F1, 1'b0);
    @(posedge clk); #1;
    cmp_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== F1) begin errors++; $display("FAIL get_out: got %b/%h expected 1/%h", out_valid, out_data, F1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL get_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL get_pulse: got %b expected 0", out_valid); end
  endtask

  task automatic test_forward();
    do_set(5'd1, F1);
    do_set(5'd2, F2);
    present(FPU_OP_FADD, 5'd1, 5'd2, 5'd5, 3'd0, 32'h0);
    #1;
    checks++; if (ex_a !== F1 || ex_b !== F2) begin errors++; $display("FAIL fadd_operands: got %h/%h expected %h/%h", ex_a, ex_b, F1, F2); end
    @(posedge clk); #1;
    complete(mk_tag(1'b0, 1'b0, 1'b1, 3'd0, 5'd5), F3, 1'b0);
    present(FPU_OP_FMUL, 5'd5, 5'd5, 5'd6, 3'd0, 32'h0);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready: got %b expected 1", req_ready); end
    checks++; if (ex_a !== F3 || ex_b !== F3) begin errors++; $display("FAIL fwd_operands: got %h/%h expected %h/%h", ex_a, ex_b, F3, F3); end
    @(posedge clk); #1;
    cmp_valid = 1'b0;
    ex_ready = 1'b0;
    present(FPU_OP_FMV, 5'd5, 5'd0, 5'd7, 3'd0, 32'h0);
    #1;
    checks++; if (ex_a !== F3 || ex_valid !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL rf_readback: got a=%h ev=%b rr=%b expected %h/1/0", ex_a, ex_valid, req_ready, F3); end
    req_valid = 1'b0;
    ex_ready = 1'b1;
    complete(mk_tag(1'b0, 1'b0, 1'b1, 3'd0, 5'd6), F9, 1'b0);
    @(posedge clk); #1;
    idle();
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL fwd_done: got busy=%b err=%b expected 0/0", busy, err); end
  endtask

  task automatic test_waw();
    present(FPU_OP_FADD, 5'd1, 5'd2, 5'd7, 3'd0, 32'h0);
    @(posedge clk); #1;
    present(FPU_OP_FSUB, 5'd1, 5'd2, 5'd7, 3'd0, 32'h0);
    #1;
    checks++; if (req_ready !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("FAIL waw_stall: got rr=%b ev=%b expected 0/0", req_ready, ex_valid); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL waw_stall2: got %b expected 0", req_ready); end
    complete(mk_tag(1'b0, 1'b0, 1'b1, 3'd0, 5'd7), F3, 1'b0);
    #1;
    checks++; if (req_ready !== 1'b1 || ex_valid !== 1'b1) begin errors++; $display("FAIL waw_release: got rr=%b ev=%b expected 1/1", req_ready, ex_valid); end
    @(posedge clk); #1;
    idle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL waw_second_busy: got %b expected 1", busy); end
    complete(mk_tag(1'b0, 1'b0, 1'b1, 3'd0, 5'd7), 32'hBF80_0000, 1'b0);
    @(posedge clk); #1;
    idle();
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL waw_done: got busy=%b err=%b expected 0/0", busy, err); end
  endtask

  task automatic test_max_inflight();
    for (int i = 0; i < 4; i++) begin
      present(FPU_OP_FADD, 5'd1, 5'd2, 5'(8 + i), 3'd0, 32'h0);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fill_%0d: got %b expected 1", i, req_ready); end
      @(posedge clk); #1;
    end
    present(FPU_OP_FADD, 5'd1, 5'd2, 5'd12, 3'd0, 32'h0);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_stall: got %b expected 0", req_ready); end
    @(posedge clk); #1;
    complete(mk_tag(1'b0, 1'b0, 1'b1, 3'd0, 5'd8), F3, 1'b0);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_release: got %b expected 1", req_ready); end
    @(posedge clk); #1;
    cmp_valid = 1'b0;
    present(FPU_OP_FADD, 5'd1, 5'd2, 5'd13, 3'd0, 32'h0);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL still_full: got %b expected 0", req_ready); end
    req_valid = 1'b0;
    for (int i = 9; i <= 12; i++) begin
      complete(mk_tag(1'b0, 1'b0, 1'b1, 3'd0, 5'(i)), F3, 1'b0);
      @(posedge clk); #1;
    end
    idle();
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL drain: got busy=%b err=%b expected 0/0", busy, err); end
  endtask

  task automatic test_compare();
    present(FPU_OP_FCLT, 5'd1, 5'd2, 5'd0, 3'd2, 32'h0);
    #1;
    checks++; if (ex_tag !== 11'h240 || ex_a !== F1 || ex_b !== F2) begin errors++; $display("FAIL fclt_issue: got tag=%h a=%h b=%h expected 240/%h/%h", ex_tag, ex_a, ex_b, F1, F2); end
    @(posedge clk); #1;
    present(FPU_OP_FCZ, 5'd1, 5'd1, 5'd0, 3'd2, 32'h0);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flag_stall: got %b expected 0", req_ready); end
    complete(11'h240, 32'h0, 1'b1);
    #1;
    checks++; if (req_ready !== 1'b1 || cond !== 8'h00) begin errors++; $display("FAIL flag_release: got rr=%b cond=%h expected 1/00", req_ready, cond); end
    @(posedge clk); #1;
    idle();
    checks++; if (cond !== 8'h04) begin errors++; $display("FAIL fclt_cond: got %h expected 04", cond); end
    complete(11'h240, 32'h0, 1'b0);
    @(posedge clk); #1;
    idle();
    checks++; if (cond !== 8'h00 || err !== 1'b0) begin errors++; $display("FAIL fcz_cond: got cond=%h err=%b expected 00/0", cond, err); end
  endtask

  task automatic test_err_and_reset();
    complete(mk_tag(1'b0, 1'b0, 1'b1, 3'd0, 5'd20), F1, 1'b0);
    @(posedge clk); #1;
    idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    present(FPU_OP_FCLT, 5'd1, 5'd2, 5'd0, 3'd1, 32'h0);
    @(posedge clk); #1;
    complete(11'h220, 32'h0, 1'b1);
    present(FPU_OP_FADD, 5'd1, 5'd2, 5'd9, 3'd0, 32'h0);
    @(posedge clk); #1;
    cmp_valid = 1'b0;
    present(FPU_OP_FADD, 5'd1, 5'd2, 5'd10, 3'd0, 32'h0);
    #1;
    checks++; if (cond !== 8'h02 || busy !== 1'b1) begin errors++; $display("FAIL pre_reset: got cond=%h busy=%b expected 02/1", cond, busy); end
    rstn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || err !== 1'b0 || cond !== 8'h00) begin errors++; $display("FAIL async_rst_state: got busy=%b err=%b cond=%h expected 0/0/00", busy, err, cond); end
    checks++; if (req_ready !== 1'b0 || ex_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_hs: got rr=%b ev=%b ov=%b expected 0/0/0", req_ready, ex_valid, out_valid); end
    idle();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_set_get();
    test_forward();
    test_waw();
    test_max_inflight();
    test_compare();
    test_err_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_regfile_ctl.md
# fpu_regfile_ctl

Parametrised FP register-file and issue controller, the successor of the single-outstanding FPU front end. Holds the FP register file and a vector of condition flags and issues operations to a pipelined execution unit with a valid/ready handshake. Tracks up to MAX_INFLIGHT outstanding operations with a per-register and per-flag scoreboard. Sits between the integer core's FPU request port and the FP arithmetic unit, forwarding completing results into newly issued operands.

## Interface
- REG_COUNT, 32, FP registers; power of two, ≥2
- DATA_W, 32, register/data width
- COND_COUNT, 8, condition flags; power of two, ≥1
- MAX_INFLIGHT, 4, max accepted-but-uncompleted ops, 1..15
- clk  in  1  clock; all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid / req_ready  in / out  1  request handshake
- req_op  in  FPU_OP_WIDTH  operation code
- req_x1, req_x2, req_y  in  log2(REG_COUNT)  source 1, source 2, destination
- req_cc  in  log2(COND_COUNT)  target flag for compare ops
- req_imm  in  DATA_W  immediate
- ex_valid / ex_ready  out / in  1  execution-unit issue handshake
- ex_op  out  FPU_OP_WIDTH  op as issued; OPFORI/OPSET/OPGET mapped to OPFOR
- ex_a, ex_b  out  DATA_W  resolved operands
- ex_tag  out  TAG_W  {ret, wcc, wreg, cc, y} completion routing
- cmp_valid  in  1  completion strobe, one cycle, any order
- cmp_tag  in  TAG_W  echoed ex_tag
- cmp_y32, cmp_y1  in  DATA_W, 1  data result, compare result
- cond  out  COND_COUNT  condition flags
- out_valid, out_data  out  1, DATA_W  data returned to the core; no back-pressure
- busy  out  1  any op in flight
- err  out  1  sticky protocol error

## Operation
- Op class decode (package): wreg (FNEG/FABS/FADD/FSUB/FMUL/FINV/ITOF/*_INIT/FMV/FORI/SET), wcc (FCLT/FCZ), ret (GET, FTOI, compares' data unused), imm1 (ITOF/SET), imm2 (FORI; SET/GET use zero).
- Operand a: imm1 ? req_imm : forward ? cmp_y32 : reg[req_x1]; b likewise with x2, zero for SET/GET.
- Forward when cmp_valid && cmp wreg && cmp y == source index.
- Hazard stall: source register busy and not being forwarded this cycle; destination register busy (WAW); target flag busy; inflight == MAX_INFLIGHT and no completion this cycle.
- ex_valid = req_valid && !stall; req_ready = ex_ready && !stall; accept = both. ex_* combinational from req_*.
- On accept: inflight+1, set busy bit of y (if wreg) or cc (if wcc).
- On cmp_valid: write reg[y] ← cmp_y32 if wreg; cond[cc] ← cmp_y1 if wcc; clear matching busy bit; inflight−1; if ret, out_valid=1, out_data=cmp_y32 next cycle.
- Accept and completion same cycle: inflight unchanged; same busy bit cleared and set → set wins.
- err set by: cmp_valid with inflight==0, or with wreg/wcc target not busy. Cleared only by reset.

## Timing
- Issue: zero latency, combinational request→ex path.
- Forward to issue operand in completion cycle; register file read shows value from next cycle.
- cond, out_valid/out_data update one cycle after cmp_valid.
- Reset: req_ready=0, ex_valid=0, cond=0, out_valid=0, out_data=0, busy=0, err=0, inflight=0, all busy bits clear. Register file contents not reset (undefined until written).
- Reset mid-operation discards in-flight state; execution unit shares rstn, so no stale completions follow.

## Structure
- fpu_pkg: FPU_OP_* codes, FPU_OP_WIDTH, op-class decode function, tag struct type.
- Sub-module fpu_scoreboard: busy bits (REG_COUNT+COND_COUNT), inflight counter, stall/err logic.
- Register file and forwarding mux in the top.

## Test plan
- Reset, then SET r3←0x3F800000 (cmp after 2 cycles), GET r3 → out_valid one cycle, out_data=0x3F800000, busy=0.
- FADD r5←r1+r2 completing at cycle N; FMUL r6←r5*r5 presented at cycle N → accepted at N with ex_a=ex_b=cmp_y32.
- FADD to r7 outstanding, second op with y=r7 → req_ready=0 until completion, accepted same cycle as cmp.
- MAX_INFLIGHT=4: five independent ops, ex_ready=1, no completions → fifth stalls; one completion → fifth accepted same cycle, inflight stays 4.
- FCLT cc=2 with 1.0<2.0 → cond=0x04 one cycle after cmp; FCZ cc=2 on 1.0 → cond=0x00.
- cmp_valid with inflight=0 → err=1 and stays 1; rstn low asynchronously mid-op → all outputs at reset values immediately.
